bar_level_meter: RTL
====================

Name: bar_level_meter

Overview:
- Parametrised bar-graph driver for the display peripheral. Successor to the fixed 3-bit to 7-segment thermometer decode.
- Takes a sampled level and drives an N-segment thermometer bar with instant attack and timed decay.
- An optional peak-hold marker holds the most recent peak, then falls toward the bar.
- Sits between the level source (RAM/sample register) and the segment output pins.

Parameters:
- LVL_W, 3, width of in_level. SEGS = 2**LVL_W-1 is derived as a localparam.
- DECAY_TICKS, 4, clock cycles per one-segment fall of bar or peak. Must be >= 1.
- HOLD_TICKS, 8, cycles the peak marker is held before it starts falling. Must be >= 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_level is sampled on this cycle
- in_level  in  LVL_W  requested bar level, 0..SEGS
- bar_out  out  SEGS  thermometer bar, fills MSB-first (level k: top k bits set)
- peak_out  out  SEGS  one-hot peak marker at bit SEGS-pk; all zero when pk==0
- level_q  out  LVL_W  current displayed level cur

Behaviour:
- Reset (asynchronous, rst_n=0): cur=0, target=0, decay_cnt=0, hold_cnt=0, pk=0, peak state=TRACK. bar_out, peak_out and level_q are all 0 immediately. Reset mid-operation aborts any decay or hold.
- Registers: cur, target, pk. bar_out and peak_out are pure decodes of the registered cur and pk, so there are no combinational input-to-output paths.
- Attack: in_valid with in_level > cur sets cur=in_level and target=in_level on that edge and clears decay_cnt. Latency to bar_out is 1 cycle.
- Release: in_valid with in_level <= cur sets target=in_level; cur is unchanged on that edge.
- Decay:
  - While cur > target, decay_cnt increments each cycle.
  - When decay_cnt==DECAY_TICKS-1: cur decrements by 1 and decay_cnt returns to 0.
  - When cur==target: decay_cnt is held at 0.
  - cur never goes below target and never wraps below 0.
- Simultaneous events:
  - Attack and decay tick on the same edge: attack wins, and decay_cnt clears.
  - Lower in_valid and tick on the same edge: the new target is used, so cur decrements by 1 only if cur > new target.
- in_valid=0: target is held and decay continues toward it.
- Peak FSM (pk never < cur):
  - TRACK: pk follows cur. If next cur > pk: pk=next cur, hold_cnt=0, go to HOLD.
  - HOLD: hold_cnt increments each cycle. A rise of cur above pk reloads pk, clears hold_cnt and stays in HOLD. At hold_cnt==HOLD_TICKS-1, go to FALL with decay_cnt_pk=0.
  - FALL: pk decrements by 1 every DECAY_TICKS cycles, using its own counter. If pk-1 <= cur, pk=cur and go to TRACK. A rise of cur above pk loads pk and goes to HOLD.
- Width rules:
  - in_level needs no saturation, since its maximum equals SEGS.
  - Counters are sized $clog2(max(DECAY_TICKS,HOLD_TICKS)+1).

Optional Feature:
- PEAK_HOLD_EN defined: the peak FSM, pk, hold_cnt and peak counter are built; peak_out behaves as specified above.
- Not defined: no peak logic is synthesised and peak_out is tied to 0. Bar behaviour is identical in both builds.

Decomposition:
- bar_meter_pkg holds:
  - the peak state enum (TRACK, HOLD, FALL);
  - a width helper for counter sizing;
  - the therm(level, SEGS) and onehot(level, SEGS) decode functions.
- Sub-module bar_therm_decoder: combinational, parameterised by LVL_W, level in and SEGS-bit MSB-first thermometer out. It is instantiated for bar_out; peak_out uses the onehot function.

Test Plan (LVL_W=3, DECAY_TICKS=4, HOLD_TICKS=8):
- Reset, then idle 10 cycles -> bar_out=0, peak_out=0, level_q=0 throughout.
- in_valid with in_level=5 for one cycle -> on the next edge bar_out=7'b1111100 and level_q=5.
- From cur=5, in_level=2 -> bar holds at 5 for 4 cycles, then steps 4, 3, 2 at 4-cycle spacing and holds at 7'b1100000.
- From cur=3 decaying toward 0, in_level=6 arrives on a tick edge -> bar_out=7'b1111110 next cycle with no extra decrement, and decay_cnt restarts.
- PEAK_HOLD_EN with in_level=7 then 0 -> peak_out=7'b0000001 for 8 cycles, then pk falls one segment per 4 cycles. pk is never below cur, reaches TRACK at 0, and peak_out=0 at the end.
- rst_n low mid-decay with cur=4, asynchronously between edges -> all outputs 0 before the next edge. After release, no residual decay or peak activity.

Source files
------------

// File: rtl/bar_meter_pkg.sv
// Shared types and decode helpers for the bar_level_meter display driver.
package bar_meter_pkg;

    typedef enum logic [1:0] {TRACK, HOLD, FALL} peak_state_t;

    // Upper bound on segment count; decode results are cast down to SEGS by the caller.
    localparam int MAX_SEGS = 255;

    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    function automatic logic [MAX_SEGS-1:0] therm(input int level, input int segs);
        logic [MAX_SEGS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_SEGS; i++)
            r[i] = (i < segs) && (i >= segs - level);
        return r;
    endfunction

    function automatic logic [MAX_SEGS-1:0] onehot(input int level, input int segs);
        logic [MAX_SEGS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_SEGS; i++)
            r[i] = (level != 0) && (i == segs - level);
        return r;
    endfunction

endpackage

// File: rtl/bar_therm_decoder.sv
// Level to MSB-first thermometer decode: level k lights the top k segments.
module bar_therm_decoder
    import bar_meter_pkg::*;
#(
    parameter int LVL_W = 3
) (
    input  logic [LVL_W-1:0]      level,
    output logic [(2**LVL_W)-2:0] therm_out
);

    localparam int SEGS = 2**LVL_W - 1;

    assign therm_out = SEGS'(therm(int'(level), SEGS));

endmodule

// File: rtl/bar_level_meter.sv
// Thermometer bar driver with instant attack and timed decay.
// Optional peak-hold marker built when PEAK_HOLD_EN is defined.
//
// peak state | meaning
// TRACK      | marker sits on the bar and follows it down
// HOLD       | marker frozen at the last peak for HOLD_TICKS cycles
// FALL       | marker steps down one segment per DECAY_TICKS cycles
module bar_level_meter
    import bar_meter_pkg::*;
#(
    parameter int LVL_W       = 3,
    parameter int DECAY_TICKS = 4,
    parameter int HOLD_TICKS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [LVL_W-1:0]      in_level,
    output logic [(2**LVL_W)-2:0] bar_out,
    output logic [(2**LVL_W)-2:0] peak_out,
    output logic [LVL_W-1:0]      level_q
);

    localparam int SEGS = 2**LVL_W - 1;
    localparam int CW   = cnt_w(DECAY_TICKS, HOLD_TICKS);
    localparam logic [CW-1:0] DEC_LAST = CW'(DECAY_TICKS - 1);

    logic [LVL_W-1:0] cur, target, cur_nxt, tgt_nxt;
    logic [CW-1:0]    decay_cnt, dcnt_nxt;

    // A lowered target takes effect on the same edge it arrives.
    always_comb begin
        tgt_nxt  = in_valid ? in_level : target;
        cur_nxt  = cur;
        dcnt_nxt = '0;
        if (in_valid && (in_level > cur)) begin
            cur_nxt = in_level;
            tgt_nxt = in_level;
        end else if (cur > tgt_nxt) begin
            if (decay_cnt == DEC_LAST)
                cur_nxt = cur - LVL_W'(1);
            else
                dcnt_nxt = decay_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            target    <= '0;
            decay_cnt <= '0;
        end else begin
            cur       <= cur_nxt;
            target    <= tgt_nxt;
            decay_cnt <= dcnt_nxt;
        end
    end

    assign level_q = cur;

    bar_therm_decoder #(.LVL_W(LVL_W)) u_bar_dec (
        .level     (cur),
        .therm_out (bar_out)
    );

`ifdef PEAK_HOLD_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);

    peak_state_t      pk_state;
    logic [LVL_W-1:0] pk;
    logic [CW-1:0]    hold_cnt, pk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_state <= TRACK;
            pk       <= '0;
            hold_cnt <= '0;
            pk_cnt   <= '0;
        end else begin
            case (pk_state)
                TRACK: begin
                    pk <= cur_nxt;
                    if (cur_nxt > pk) begin
                        hold_cnt <= '0;
                        pk_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cur_nxt > pk) begin
                        pk       <= cur_nxt;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        pk_cnt   <= '0;
                        pk_state <= FALL;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                FALL: begin
                    if (cur_nxt > pk) begin
                        pk       <= cur_nxt;
                        hold_cnt <= '0;
                        pk_state <= HOLD;
                    end else if (pk_cnt == DEC_LAST) begin
                        pk_cnt <= '0;
                        // widened compare so cur_nxt at full scale cannot wrap
                        if ({1'b0, pk} <= ({1'b0, cur_nxt} + (LVL_W+1)'(1))) begin
                            pk       <= cur_nxt;
                            pk_state <= TRACK;
                        end else begin
                            pk <= pk - LVL_W'(1);
                        end
                    end else begin
                        pk_cnt <= pk_cnt + CW'(1);
                    end
                end
                default: pk_state <= TRACK;
            endcase
        end
    end

    assign peak_out = SEGS'(onehot(int'(pk), SEGS));
`else
    assign peak_out = '0;
`endif

endmodule
